ray_dispatcher: RTL and testbench



---
 rtl/ray_pkg.sv | 21 ++
 rtl/ray_dispatcher_if.sv | 27 ++
 rtl/ray_fifo2.sv | 60 ++++++
 rtl/ray_dispatcher.sv | 99 +++++++++
 tb/tb_ray_dispatcher.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ray_pkg.sv
// Shared ray types and occupancy encoding for the ray dispatcher.
package ray_pkg;
    localparam int POSITION_WIDTH = 16;
    localparam int ADDRESS_WIDTH  = 32;
    localparam int MAX_UNITS      = 8;

    typedef logic signed [POSITION_WIDTH-1:0] pos_t;
    // Index 0/1/2 = x/y/z.
    typedef pos_t [2:0] vec_t;

    typedef struct packed {
        vec_t                     v;
        logic [ADDRESS_WIDTH-1:0] address;
    } ray_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;
endpackage

// File: rtl/ray_dispatcher_if.sv
// Ray generator / ray unit bundle seen by the dispatcher (master) and its environment (slave).
interface ray_dispatcher_if #(parameter int UNITS = 4);
    import ray_pkg::*;

    logic                     flush;
    logic                     inStart;
    logic                     inReady;
    vec_t                     inV;
    logic [ADDRESS_WIDTH-1:0] inAddress;
    logic [UNITS-1:0]         outStart;
    vec_t                     outV;
    logic [ADDRESS_WIDTH-1:0] outAddress;
    logic [UNITS-1:0]         unitReady;
    logic [UNITS-1:0]         unitBusy;
    logic                     busy;
    logic [31:0]              rayCount;

    modport master (
        input  flush, inStart, inV, inAddress, unitReady, unitBusy,
        output inReady, outStart, outV, outAddress, busy, rayCount
    );

    modport slave (
        output flush, inStart, inV, inAddress, unitReady, unitBusy,
        input  inReady, outStart, outV, outAddress, busy, rayCount
    );
endinterface

// File: rtl/ray_fifo2.sv
// Two-entry ray queue; head is a register, push/pop take effect at the next edge.
// Never pushed when FULL (caller gates push with its ready); flush empties it.
module ray_fifo2
    import ray_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  ray_t din,
    output occ_t count,
    output ray_t head
);
    occ_t state;
    occ_t state_nxt;
    ray_t tail;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (push) state_nxt = ONE;
                ONE: begin
                    if (push && !pop)      state_nxt = FULL;
                    else if (pop && !push) state_nxt = EMPTY;
                end
                FULL:    if (pop) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else if (!flush) begin
            case (state)
                EMPTY: if (push) head <= din;
                ONE: begin
                    // Simultaneous push/pop with one entry: the new ray replaces the head.
                    if (push && pop) head <= din;
                    else if (push)   tail <= din;
                end
                FULL:  if (pop) head <= tail;
                default: ;
            endcase
        end
    end

    assign count = state;
endmodule

// File: rtl/ray_dispatcher.sv
// Round-robin ray issue to UNITS ray units; issue pulse 2 cycles after acceptance into an empty queue.
// Upstream stalls via inReady when the 2-entry queue is full or flushing; RAY_DISPATCH_COUNT_EN adds rayCount.
module ray_dispatcher
    import ray_pkg::*;
#(
    parameter int UNITS = 4
)
(
    input  logic             clock,
    input  logic             reset,
    ray_dispatcher_if.master bus
);
    localparam int PW = $clog2(UNITS);

    occ_t             count;
    ray_t             head;
    ray_t             in_ray;
    logic             push;
    logic             issue;
    logic [UNITS-1:0] elig;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    sel;

    function automatic logic [PW-1:0] rr_pick(input logic [UNITS-1:0] req,
                                              input logic [PW-1:0]    start);
        logic [PW-1:0] pick;
        logic          hit;
        int            idx;
        pick = start;
        hit  = 1'b0;
        for (int k = 0; k < UNITS; k++) begin
            idx = (int'(start) + k) % UNITS;
            if (!hit && req[idx]) begin
                pick = PW'(idx);
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

    assign in_ray      = {bus.inV, bus.inAddress};
    assign bus.inReady = (count != FULL) && !bus.flush;
    assign push        = bus.inStart && bus.inReady;

    // The registered pulse doubles as the one-cycle mask, so a unit cannot win
    // again while its ready has not yet reacted to the pulse.
    assign elig  = bus.unitReady & ~bus.outStart;
    assign sel   = rr_pick(elig, ptr);
    assign issue = (count != EMPTY) && (|elig) && !bus.flush;

    assign bus.busy = (count != EMPTY) || (|bus.outStart) || (|bus.unitBusy);

    ray_fifo2 u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (issue),
        .flush (bus.flush),
        .din   (in_ray),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.outStart <= '0;
            ptr          <= '0;
        end else if (bus.flush) begin
            bus.outStart <= '0;
            ptr          <= '0;
        end else begin
            bus.outStart <= issue ? (UNITS'(1) << sel) : '0;
            if (issue) ptr <= (sel == PW'(UNITS-1)) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.outV       <= '0;
            bus.outAddress <= '0;
        end else if (issue) begin
            bus.outV       <= head.v;
            bus.outAddress <= head.address;
        end
    end

`ifdef RAY_DISPATCH_COUNT_EN
    logic [31:0] ray_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)      ray_cnt <= '0;
        else if (issue) ray_cnt <= ray_cnt + 32'd1;
    end

    assign bus.rayCount = ray_cnt;
`else
    assign bus.rayCount = '0;
`endif
endmodule

// File: tb/tb_ray_dispatcher.sv
// Bench for ray_dispatcher: directed table, corner sequences, randomized run against a queue model.
module tb_ray_dispatcher;
    import ray_pkg::*;

    localparam int UNITS = 4;
`ifdef RAY_DISPATCH_COUNT_EN
    localparam logic [31:0] CNT_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] CNT_MASK = 32'h0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    ray_dispatcher_if #(.UNITS(UNITS)) bus ();

    ray_dispatcher #(.UNITS(UNITS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       st;
        ray_t       r;
        logic       fl;
        logic [3:0] e_os;
        logic       e_ir;
        logic       chk_d;
        ray_t       e_r;
        int         e_cnt;
    } rec_t;

    rec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ray_t mkray(input int x, input int y, input int z, input logic [31:0] a);
        ray_t r;
        r.v[0]    = 16'(x);
        r.v[1]    = 16'(y);
        r.v[2]    = 16'(z);
        r.address = a;
        return r;
    endfunction

    function automatic rec_t rec(input logic st, input ray_t r, input logic fl,
                                 input logic [3:0] e_os, input logic e_ir,
                                 input logic chk_d, input ray_t e_r, input int e_cnt);
        rec_t t;
        t.st = st; t.r = r; t.fl = fl; t.e_os = e_os; t.e_ir = e_ir;
        t.chk_d = chk_d; t.e_r = e_r; t.e_cnt = e_cnt;
        return t;
    endfunction

    function automatic logic [31:0] ecnt(input int n);
        return 32'(n) & CNT_MASK;
    endfunction

    task automatic drive_ray(input logic st, input ray_t r);
        bus.inStart   = st;
        bus.inV       = r.v;
        bus.inAddress = r.address;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench at posedge+1 with reset released and all inputs idle.
    task automatic do_reset();
        bus.inStart = 1'b0; bus.flush = 1'b0; bus.inV = '0; bus.inAddress = '0;
        bus.unitReady = '0; bus.unitBusy = '0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic chk_issue(input string name, input logic [3:0] os, input ray_t r);
        chk({name, ".outStart"}, bus.outStart, os);
        chk({name, ".outV"}, bus.outV, r.v);
        chk({name, ".outAddress"}, bus.outAddress, r.address);
    endtask

    // Reference model state
    ray_t        mq[$];
    int          m_ptr;
    int          m_pulse;
    ray_t        m_out;
    int unsigned m_cnt;

    initial begin
        ray_t ra, rz, b[3], m[2], g[2], cur;
        ray_t rr[6];
        logic e_ir, e_busy;
        int sel;

        bus.inStart = 1'b0; bus.flush = 1'b0; bus.inV = '0; bus.inAddress = '0;
        bus.unitReady = '0; bus.unitBusy = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        chk("rst.outStart", bus.outStart, 4'b0000);
        chk("rst.outV", bus.outV, 48'h0);
        chk("rst.outAddress", bus.outAddress, 32'h0);
        chk("rst.rayCount", bus.rayCount, 32'h0);
        chk("rst.inReady", bus.inReady, 1'b1);
        chk("rst.busy", bus.busy, 1'b0);
        bus.unitBusy = 4'b0100;
        #1;
        chk("rst.busyUnit", bus.busy, 1'b1);
        bus.unitBusy = '0;
        next_cycle();

        // Directed table: single ray latency, flush resets ptr, round-robin stream
        rz = '0;
        ra = mkray(1, 2, 3, 32'h100);
        for (int k = 0; k < 6; k++) rr[k] = mkray(10 + k, 20 + k, -1 - k, 32'h200 + 32'(4 * k));
        tbl.push_back(rec(1, ra,    0, 4'b0000, 1, 0, rz,    0));
        tbl.push_back(rec(0, rz,    0, 4'b0000, 1, 0, rz,    0));
        tbl.push_back(rec(0, rz,    0, 4'b0001, 1, 1, ra,    1));
        tbl.push_back(rec(0, rz,    1, 4'b0000, 0, 1, ra,    1));
        tbl.push_back(rec(1, rr[0], 0, 4'b0000, 1, 1, ra,    1));
        tbl.push_back(rec(1, rr[1], 0, 4'b0000, 1, 1, ra,    1));
        tbl.push_back(rec(1, rr[2], 0, 4'b0001, 1, 1, rr[0], 2));
        tbl.push_back(rec(1, rr[3], 0, 4'b0010, 1, 1, rr[1], 3));
        tbl.push_back(rec(1, rr[4], 0, 4'b0100, 1, 1, rr[2], 4));
        tbl.push_back(rec(1, rr[5], 0, 4'b1000, 1, 1, rr[3], 5));
        tbl.push_back(rec(0, rz,    0, 4'b0001, 1, 1, rr[4], 6));
        tbl.push_back(rec(0, rz,    0, 4'b0010, 1, 1, rr[5], 7));
        tbl.push_back(rec(0, rz,    0, 4'b0000, 1, 1, rr[5], 7));

        bus.unitReady = 4'b1111;
        foreach (tbl[i]) begin
            drive_ray(tbl[i].st, tbl[i].r);
            bus.flush = tbl[i].fl;
            @(negedge clock);
            chk($sformatf("tbl%0d.outStart", i), bus.outStart, tbl[i].e_os);
            chk($sformatf("tbl%0d.inReady", i), bus.inReady, tbl[i].e_ir);
            chk($sformatf("tbl%0d.rayCount", i), bus.rayCount, ecnt(tbl[i].e_cnt));
            if (tbl[i].chk_d) begin
                chk($sformatf("tbl%0d.outV", i), bus.outV, tbl[i].e_r.v);
                chk($sformatf("tbl%0d.outAddress", i), bus.outAddress, tbl[i].e_r.address);
            end
            next_cycle();
        end

        // Backpressure: no unit ready, third push held, then unit 2 drains
        do_reset();
        for (int k = 0; k < 3; k++) b[k] = mkray(100 + k, -200, 7 * k, 32'hB000 + 32'(k));
        drive_ray(1, b[0]); @(negedge clock); chk("bp.ir0", bus.inReady, 1'b1); next_cycle();
        drive_ray(1, b[1]); @(negedge clock); chk("bp.ir1", bus.inReady, 1'b1); next_cycle();
        drive_ray(1, b[2]); @(negedge clock); chk("bp.held", bus.inReady, 1'b0); next_cycle();
        bus.unitReady = 4'b0100;
        @(negedge clock);
        chk("bp.stillFull", bus.inReady, 1'b0);
        chk("bp.noIssue", bus.outStart, 4'b0000);
        next_cycle();
        @(negedge clock);
        chk_issue("bp.u2", 4'b0100, b[0]);
        chk("bp.irBack", bus.inReady, 1'b1);
        next_cycle();
        bus.inStart = 1'b0;
        bus.unitReady = 4'b1111;
        @(negedge clock);
        chk("bp.mask2", bus.outStart, 4'b0000);
        chk("bp.full2", bus.inReady, 1'b0);
        next_cycle();
        @(negedge clock); chk_issue("bp.u3", 4'b1000, b[1]); next_cycle();
        @(negedge clock); chk_issue("bp.u0", 4'b0001, b[2]); chk("bp.busyPulse", bus.busy, 1'b1); next_cycle();
        @(negedge clock); chk("bp.idle", bus.outStart, 4'b0000); chk("bp.busyLow", bus.busy, 1'b0); next_cycle();

        // Mask: single steadily ready unit gets every other cycle
        do_reset();
        bus.unitReady = 4'b0010;
        m[0] = mkray(-5, 6, -7, 32'hCAFE0000);
        m[1] = mkray(8, -9, 10, 32'hCAFE0004);
        drive_ray(1, m[0]); next_cycle();
        drive_ray(1, m[1]); @(negedge clock); chk("mask.ir", bus.inReady, 1'b1); next_cycle();
        bus.inStart = 1'b0;
        @(negedge clock); chk_issue("mask.p0", 4'b0010, m[0]); next_cycle();
        @(negedge clock); chk("mask.gap", bus.outStart, 4'b0000); next_cycle();
        @(negedge clock); chk_issue("mask.p1", 4'b0010, m[1]); next_cycle();
        @(negedge clock); chk("mask.end", bus.outStart, 4'b0000); next_cycle();

        // Flush a full queue while units become ready and a push is attempted
        do_reset();
        drive_ray(1, mkray(1, 1, 1, 32'hF0)); next_cycle();
        drive_ray(1, mkray(2, 2, 2, 32'hF1)); next_cycle();
        drive_ray(1, mkray(3, 3, 3, 32'hF2));
        bus.flush = 1'b1;
        bus.unitReady = 4'b1111;
        @(negedge clock); chk("fl.irLow", bus.inReady, 1'b0); next_cycle();
        bus.flush = 1'b0;
        bus.inStart = 1'b0;
        @(negedge clock);
        chk("fl.noPulse", bus.outStart, 4'b0000);
        chk("fl.irHigh", bus.inReady, 1'b1);
        chk("fl.busy", bus.busy, 1'b0);
        next_cycle();
        @(negedge clock);
        chk("fl.dropped", bus.outStart, 4'b0000);
        chk("fl.rayCount", bus.rayCount, 32'h0);
        next_cycle();

        // Asynchronous reset while a pulse is on the wire
        do_reset();
        bus.unitReady = 4'b0100;
        g[0] = mkray(11, 12, 13, 32'h4000);
        g[1] = mkray(14, 15, 16, 32'h4004);
        drive_ray(1, g[0]); next_cycle();
        drive_ray(1, g[1]); next_cycle();
        bus.inStart = 1'b0;
        @(negedge clock);
        chk_issue("ar.pre", 4'b0100, g[0]);
        chk("ar.preCount", bus.rayCount, ecnt(1));
        #2;
        reset = 1'b1;
        #1;
        chk("ar.outStart", bus.outStart, 4'b0000);
        chk("ar.rayCount", bus.rayCount, 32'h0);
        chk("ar.outV", bus.outV, 48'h0);
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk($sformatf("ar.post%0d", k), bus.outStart, 4'b0000);
            chk($sformatf("ar.busy%0d", k), bus.busy, 1'b0);
            next_cycle();
        end

        // Randomized traffic against a queue-level model
        do_reset();
        mq.delete();
        m_ptr = 0; m_pulse = -1; m_out = '0; m_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            cur = mkray(int'($urandom), int'($urandom), int'($urandom), 32'($urandom));
            drive_ray($urandom_range(0, 9) < 7, cur);
            bus.unitReady = 4'($urandom);
            bus.unitBusy  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            bus.flush     = ($urandom_range(0, 31) == 0);
            @(negedge clock);

            e_ir   = (mq.size() < 2) && !bus.flush;
            e_busy = (mq.size() > 0) || (m_pulse >= 0) || (|bus.unitBusy);
            chk($sformatf("rnd%0d.outStart", c), bus.outStart, (m_pulse >= 0) ? (4'b0001 << m_pulse) : 4'b0000);
            chk($sformatf("rnd%0d.outV", c), bus.outV, m_out.v);
            chk($sformatf("rnd%0d.outAddress", c), bus.outAddress, m_out.address);
            chk($sformatf("rnd%0d.rayCount", c), bus.rayCount, ecnt(int'(m_cnt)));
            chk($sformatf("rnd%0d.inReady", c), bus.inReady, e_ir);
            chk($sformatf("rnd%0d.busy", c), bus.busy, e_busy);

            if (bus.flush) begin
                mq.delete();
                m_ptr = 0;
                m_pulse = -1;
            end else begin
                sel = -1;
                if (mq.size() > 0) begin
                    for (int k = 0; k < UNITS; k++) begin
                        int u;
                        u = (m_ptr + k) % UNITS;
                        if (sel < 0 && bus.unitReady[u] && u != m_pulse) sel = u;
                    end
                end
                if (sel >= 0) begin
                    m_out = mq.pop_front();
                    m_cnt++;
                    m_ptr = (sel + 1) % UNITS;
                end
                m_pulse = sel;
                if (bus.inStart && e_ir) mq.push_back(cur);
            end
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
